// File: rtl/fpu.sv
// Two-stage single-precision FP add/sub/mul/div with IEEE rounding and status flags.
// Define FPU_DIV_EN to build the divider; without it fpu_op=3 is handled as reserved.
module fpu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  rmode,
    input  logic [2:0]  fpu_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [31:0] out,
    output logic        snan,
    output logic        qnan,
    output logic        inf,
    output logic        ine,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        zero
);

    typedef struct packed {
        logic snan;
        logic qnan;
        logic inf;
        logic ine;
        logic ovf;
        logic unf;
        logic dbz;
        logic zero;
    } flags_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] MAG_INF = 31'h7F80_0000;
    localparam logic [30:0] MAG_MAX = 31'h7F7F_FFFF;

    logic [31:0] opa_q, opb_q;
    logic [2:0]  op_q;
    logic [1:0]  rmode_q;
    logic [31:0] out_d, out_q;
    flags_t      flg_d, flg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            op_q    <= 3'd0;
            rmode_q <= 2'd0;
        end else begin
            opa_q   <= opa;
            opb_q   <= opb;
            op_q    <= fpu_op;
            rmode_q <= rmode;
        end
    end

    // Operand unpacking; denormals collapse to signed zero
    logic        sa, sb, sb_eff, sx;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        za, zb, ia, ib, na, nb, sna, snb;
    logic [23:0] ma, mb;

    assign sa  = opa_q[31];
    assign sb  = opb_q[31];
    assign ea  = opa_q[30:23];
    assign eb  = opb_q[30:23];
    assign fa  = opa_q[22:0];
    assign fb  = opb_q[22:0];
    assign za  = (ea == 8'd0);
    assign zb  = (eb == 8'd0);
    assign ia  = (ea == 8'hFF) && (fa == 23'd0);
    assign ib  = (eb == 8'hFF) && (fb == 23'd0);
    assign na  = (ea == 8'hFF) && (fa != 23'd0);
    assign nb  = (eb == 8'hFF) && (fb != 23'd0);
    assign sna = na && !fa[22];
    assign snb = nb && !fb[22];
    assign ma  = za ? 24'd0 : {1'b1, fa};
    assign mb  = zb ? 24'd0 : {1'b1, fb};
    assign sx  = sa ^ sb;

    logic is_add, is_sub, is_mul, is_div, rsvd;
    assign is_add = (op_q == 3'd0);
    assign is_sub = (op_q == 3'd1);
    assign is_mul = (op_q == 3'd2);
`ifdef FPU_DIV_EN
    assign is_div = (op_q == 3'd3);
`else
    assign is_div = 1'b0;
`endif
    assign rsvd   = !(is_add || is_sub || is_mul || is_div);
    assign sb_eff = sb ^ is_sub;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // Add/sub: larger magnitude first, smaller aligned with G/R/S
    logic        a_ge, sl, ss;
    logic [7:0]  el, es, ed;
    logic [23:0] ml, ms;
    logic [49:0] sh_full;
    logic [26:0] ms_al;
    logic [27:0] ml_ext, add_raw;
    logic [4:0]  add_lz;
    logic [26:0] add_sig;
    logic signed [10:0] add_e;
    logic        add_zero, add_sign;

    assign a_ge    = {ea, fa} >= {eb, fb};
    assign el      = a_ge ? ea : eb;
    assign es      = a_ge ? eb : ea;
    assign ml      = a_ge ? ma : mb;
    assign ms      = a_ge ? mb : ma;
    assign sl      = a_ge ? sa : sb_eff;
    assign ss      = a_ge ? sb_eff : sa;
    assign ed      = el - es;
    assign sh_full = {ms, 26'd0} >> ed;
    assign ms_al   = (ed >= 8'd26) ? {26'd0, |ms}
                                   : {sh_full[49:24], |sh_full[23:0]};
    assign ml_ext  = {1'b0, ml, 3'b000};
    assign add_raw = (sl == ss) ? ml_ext + {1'b0, ms_al}
                                : ml_ext - {1'b0, ms_al};
    assign add_lz  = lzc27(add_raw[26:0]);
    assign add_zero = (add_raw == 28'd0);

    always_comb begin
        add_sig = add_raw[26:0] << add_lz;
        add_e   = $signed({3'd0, el}) - $signed({6'd0, add_lz});
        if (add_raw[27]) begin
            add_sig = {add_raw[27:2], add_raw[1] | add_raw[0]};
            add_e   = $signed({3'd0, el}) + 11'sd1;
        end
        add_sign = sl;
        if (add_zero) add_sign = (sl == ss) ? sl : (rmode_q == 2'd3);
    end

    // Mul: 24x24 product normalised to 1.x with G/R/S
    logic [47:0] prod;
    logic [26:0] mul_sig;
    logic signed [10:0] mul_e;

    assign prod    = ma * mb;
    assign mul_sig = prod[47] ? {prod[47:22], |prod[21:0]}
                              : {prod[46:21], |prod[20:0]};
    assign mul_e   = $signed({3'd0, ea}) + $signed({3'd0, eb})
                   - 11'sd127 + $signed({10'd0, prod[47]});

`ifdef FPU_DIV_EN
    // Div: quotient carries 26 extra bits, remainder folds into sticky
    logic [49:0] dv_num, dv_den, dv_quo, dv_rem;
    logic [26:0] div_sig;
    logic signed [10:0] div_e;
    logic        dv_rnz;

    assign dv_num  = {ma, 26'd0};
    assign dv_den  = {26'd0, zb ? 24'd1 : mb};
    assign dv_quo  = dv_num / dv_den;
    assign dv_rem  = dv_num % dv_den;
    assign dv_rnz  = |dv_rem;
    assign div_sig = dv_quo[26] ? {dv_quo[26:1], dv_quo[0] | dv_rnz}
                                : {dv_quo[25:0], dv_rnz};
    assign div_e   = $signed({3'd0, ea}) - $signed({3'd0, eb})
                   + 11'sd127 - $signed({10'd0, !dv_quo[26]});
`endif

    logic        r_sign, r_zero;
    logic [26:0] r_sig;
    logic signed [10:0] r_e;

    always_comb begin
        r_sign = sx;
        r_sig  = mul_sig;
        r_e    = mul_e;
        r_zero = 1'b0;
        if (is_add || is_sub) begin
            r_sign = add_sign;
            r_sig  = add_sig;
            r_e    = add_e;
            r_zero = add_zero;
        end
`ifdef FPU_DIV_EN
        else if (is_div) begin
            r_sig = div_sig;
            r_e   = div_e;
        end
`endif
    end

    // Rounding and packing of the finite arithmetic result
    logic        rg, rs, inc, inexact, ovf_inf;
    logic [24:0] m25;
    logic [22:0] rfrac;
    logic signed [10:0] re_r;

    assign rg      = r_sig[2];
    assign rs      = r_sig[1] | r_sig[0];
    assign inexact = rg | rs;

    always_comb begin
        inc = 1'b0;
        unique case (rmode_q)
            2'd0: inc = rg & (rs | r_sig[3]);
            2'd1: inc = 1'b0;
            2'd2: inc = !r_sign & inexact;
            2'd3: inc = r_sign & inexact;
        endcase
    end

    assign m25     = {1'b0, r_sig[26:3]} + {24'd0, inc};
    assign re_r    = r_e + $signed({10'd0, m25[24]});
    assign rfrac   = m25[24] ? m25[23:1] : m25[22:0];
    assign ovf_inf = (rmode_q == 2'd0) || (rmode_q == 2'd2 && !r_sign)
                  || (rmode_q == 2'd3 && r_sign);

    logic [31:0] ar_out;
    flags_t      ar_flg;

    always_comb begin
        ar_out = 32'd0;
        ar_flg = '0;
        if (r_zero) begin
            ar_out      = {r_sign, 31'd0};
            ar_flg.zero = 1'b1;
        end else if (r_e < 11'sd1) begin
            ar_out      = {r_sign, 31'd0};
            ar_flg.unf  = 1'b1;
            ar_flg.ine  = 1'b1;
            ar_flg.zero = 1'b1;
        end else if (re_r > 11'sd254) begin
            ar_flg.ovf = 1'b1;
            ar_flg.ine = 1'b1;
            if (ovf_inf) begin
                ar_out     = {r_sign, MAG_INF};
                ar_flg.inf = 1'b1;
            end else begin
                ar_out = {r_sign, MAG_MAX};
            end
        end else begin
            ar_out     = {r_sign, re_r[7:0], rfrac};
            ar_flg.ine = inexact;
        end
    end

    // Special operands take priority over the arithmetic result
    always_comb begin
        out_d = 32'd0;
        flg_d = '0;
        if (rsvd) begin
            out_d      = QNAN;
            flg_d.qnan = 1'b1;
        end else if (na || nb) begin
            out_d      = QNAN;
            flg_d.qnan = 1'b1;
            flg_d.snan = sna || snb;
        end else if (is_mul) begin
            if ((ia || ib) && (za || zb)) begin
                out_d      = QNAN;
                flg_d.qnan = 1'b1;
            end else if (ia || ib) begin
                out_d     = {sx, MAG_INF};
                flg_d.inf = 1'b1;
            end else if (za || zb) begin
                out_d      = {sx, 31'd0};
                flg_d.zero = 1'b1;
            end else begin
                out_d = ar_out;
                flg_d = ar_flg;
            end
        end
`ifdef FPU_DIV_EN
        else if (is_div) begin
            if ((za && zb) || (ia && ib)) begin
                out_d      = QNAN;
                flg_d.qnan = 1'b1;
            end else if (ia) begin
                out_d     = {sx, MAG_INF};
                flg_d.inf = 1'b1;
            end else if (ib) begin
                out_d      = {sx, 31'd0};
                flg_d.zero = 1'b1;
            end else if (zb) begin
                out_d     = {sx, MAG_INF};
                flg_d.inf = 1'b1;
                flg_d.dbz = 1'b1;
            end else if (za) begin
                out_d      = {sx, 31'd0};
                flg_d.zero = 1'b1;
            end else begin
                out_d = ar_out;
                flg_d = ar_flg;
            end
        end
`endif
        else begin
            if (ia && ib && (sa != sb_eff)) begin
                out_d      = QNAN;
                flg_d.qnan = 1'b1;
            end else if (ia || ib) begin
                out_d     = {ia ? sa : sb_eff, MAG_INF};
                flg_d.inf = 1'b1;
            end else begin
                out_d = ar_out;
                flg_d = ar_flg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 32'd0;
            flg_q <= '0;
        end else begin
            out_q <= out_d;
            flg_q <= flg_d;
        end
    end

    assign out         = out_q;
    assign snan        = flg_q.snan;
    assign qnan        = flg_q.qnan;
    assign inf         = flg_q.inf;
    assign ine         = flg_q.ine;
    assign overflow    = flg_q.ovf;
    assign underflow   = flg_q.unf;
    assign div_by_zero = flg_q.dbz;
    assign zero        = flg_q.zero;

    logic unused_ok;
`ifdef FPU_DIV_EN
    assign unused_ok = ^{re_r[10:8], dv_quo[49:27]};
`else
    assign unused_ok = ^{re_r[10:8]};
`endif

endmodule

// File: tb/tb_fpu.sv
// Directed-vector bench for fpu: reset, arithmetic, rounding, specials, throughput.
// Division expectations follow FPU_DIV_EN.
module tb_fpu;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rmode;
    logic [2:0]  fpu_op;
    logic [31:0] opa, opb, out;
    logic        snan, qnan, inf, ine, overflow, underflow, div_by_zero, zero;
    logic [7:0]  flags;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] F_SN   = 8'h80;
    localparam logic [7:0] F_QN   = 8'h40;
    localparam logic [7:0] F_INF  = 8'h20;
    localparam logic [7:0] F_INE  = 8'h10;
    localparam logic [7:0] F_OVF  = 8'h08;
    localparam logic [7:0] F_UNF  = 8'h04;
    localparam logic [7:0] F_DBZ  = 8'h02;
    localparam logic [7:0] F_ZERO = 8'h01;

    localparam logic [31:0] A24 = 32'h41C0_0000;
    localparam logic [31:0] B10 = 32'h4120_0000;
    localparam logic [31:0] QN  = 32'h7FC0_0000;

`ifdef FPU_DIV_EN
    localparam logic [31:0] DIV_RNE = 32'h4019_999A;
    localparam logic [31:0] DIV_RZ  = 32'h4019_9999;
    localparam logic [7:0]  DIV_F   = F_INE;
    localparam logic [31:0] DZ_OUT  = 32'h7F80_0000;
    localparam logic [7:0]  DZ_F    = F_INF | F_DBZ;
`else
    localparam logic [31:0] DIV_RNE = QN;
    localparam logic [31:0] DIV_RZ  = QN;
    localparam logic [7:0]  DIV_F   = F_QN;
    localparam logic [31:0] DZ_OUT  = QN;
    localparam logic [7:0]  DZ_F    = F_QN;
`endif

    assign flags = {snan, qnan, inf, ine, overflow, underflow, div_by_zero, zero};

    fpu dut (
        .clk(clk),
        .rst_n(rst_n),
        .rmode(rmode),
        .fpu_op(fpu_op),
        .opa(opa),
        .opb(opb),
        .out(out),
        .snan(snan),
        .qnan(qnan),
        .inf(inf),
        .ine(ine),
        .overflow(overflow),
        .underflow(underflow),
        .div_by_zero(div_by_zero),
        .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] rm,
                         input logic [31:0] a, input logic [31:0] b);
        fpu_op = op;
        rmode  = rm;
        opa    = a;
        opb    = b;
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [1:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eo,
                       input logic [7:0] ef);
        drive(op, rm, a, b);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(tag, out, eo);
        chk({tag, ".flags"}, {24'd0, flags}, {24'd0, ef});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(3'd0, 2'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out", out, 32'd0);
        chk("reset.flags", {24'd0, flags}, 32'd0);
        rst_n = 1'b1;

        run("add", 3'd0, 2'd0, A24, B10, 32'h4208_0000, 8'h00);
        run("sub", 3'd1, 2'd0, A24, B10, 32'h4160_0000, 8'h00);
        run("mul", 3'd2, 2'd0, A24, B10, 32'h4370_0000, 8'h00);
        run("div.rne", 3'd3, 2'd0, A24, B10, DIV_RNE, DIV_F);
        run("div.rz", 3'd3, 2'd1, A24, B10, DIV_RZ, DIV_F);
        run("div.by0", 3'd3, 2'd0, 32'h3F80_0000, 32'd0, DZ_OUT, DZ_F);

        run("inf-inf", 3'd0, 2'd0, 32'h7F80_0000, 32'hFF80_0000, QN, F_QN);
        run("snan", 3'd0, 2'd0, 32'h7F80_0001, 32'h3F80_0000, QN, F_QN | F_SN);
        run("rsvd", 3'd5, 2'd0, A24, B10, QN, F_QN);

        run("ovf.rne", 3'd0, 2'd0, 32'h7F7F_FFFF, 32'h7F7F_FFFF,
            32'h7F80_0000, F_OVF | F_INF | F_INE);
        run("ovf.rz", 3'd0, 2'd1, 32'h7F7F_FFFF, 32'h7F7F_FFFF,
            32'h7F7F_FFFF, F_OVF | F_INE);

        run("unf.mul", 3'd2, 2'd0, 32'h0080_0000, 32'h3F00_0000,
            32'h0000_0000, F_UNF | F_INE | F_ZERO);
        run("x-x.rne", 3'd1, 2'd0, A24, A24, 32'h0000_0000, F_ZERO);
        run("x-x.rdn", 3'd1, 2'd3, A24, A24, 32'h8000_0000, F_ZERO);
        run("nz+nz", 3'd0, 2'd0, 32'h8000_0000, 32'h8000_0000,
            32'h8000_0000, F_ZERO);

        run("tie.rne", 3'd0, 2'd0, 32'h3F80_0000, 32'h3380_0000,
            32'h3F80_0000, F_INE);
        run("tie.rup", 3'd0, 2'd2, 32'h3F80_0000, 32'h3380_0000,
            32'h3F80_0001, F_INE);

        drive(3'd0, 2'd0, A24, B10);
        @(posedge clk);
        #1;
        drive(3'd1, 2'd0, A24, B10);
        @(posedge clk);
        #1;
        chk("tp.add", out, 32'h4208_0000);
        drive(3'd2, 2'd0, A24, B10);
        @(posedge clk);
        #1;
        chk("tp.sub", out, 32'h4160_0000);
        drive(3'd3, 2'd0, A24, B10);
        @(posedge clk);
        #1;
        chk("tp.mul", out, 32'h4370_0000);
        drive(3'd0, 2'd0, A24, B10);
        @(posedge clk);
        #1;
        chk("tp.div", out, DIV_RNE);

        rst_n = 1'b0;
        #1;
        chk("rst.mid.out", out, 32'd0);
        chk("rst.mid.flags", {24'd0, flags}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.resume", out, 32'h4208_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
